sdram_model: RTL and testbench

SDRAM_MODEL -- requirements
Module: sdram_model

---
 rtl/sdram_model.sv | 251 +++++++++++++++++++++++++
 tb/tb_sdram_model.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_model.sv
// SDRAM behavioural target model: decodes SDR SDRAM commands from a
// controller sharing clk, tracks power-up, banks, mode and bursts, stores
// 16-bit words and returns read bursts with CAS latency, flagging protocol
// violations on a sticky error vector.
module sdram_model #(
  parameter int ROW_BITS   = 4,
  parameter int INIT_CHECK = 1
) (
  input  logic        clk,
  input  logic        init,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic [1:0]  SDRAM_BA,
  input  logic [12:0] SDRAM_A,
  input  logic        SDRAM_DQMH,
  input  logic        SDRAM_DQML,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        ready,
  output logic [4:0]  err
);

  localparam int AW    = 2 + ROW_BITS + 9;
  localparam int DEPTH = 1 << AW;

  localparam logic [3:0] CMD_LMR    = 4'b0000;
  localparam logic [3:0] CMD_REF    = 4'b0001;
  localparam logic [3:0] CMD_PRE    = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_WRITE  = 4'b0100;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_BST    = 4'b0110;

  typedef enum logic [2:0] {
    WAIT_PRE, WAIT_REF1, WAIT_REF2, WAIT_MODE, RUN
  } pwr_state_t;

  // Column of burst word k: sequential wraps inside the BL-aligned block,
  // interleaved flips the low column bits.
  function automatic logic [8:0] burst_col(input logic [8:0] col, input logic [2:0] k,
                                           input logic [1:0] bl_log2, input logic ilv);
    logic [8:0] mask;
    logic [8:0] kk;
    mask = 9'((1 << bl_log2) - 1);
    kk   = {6'd0, k};
    if (ilv) return col ^ kk;
    return (col & ~mask) | ((col + kk) & mask);
  endfunction

  // A masked byte lane reads back as zero.
  function automatic logic [15:0] mask_read(input logic [15:0] d, input logic [1:0] dqm);
    return {dqm[1] ? 8'h00 : d[15:8], dqm[0] ? 8'h00 : d[7:0]};
  endfunction

  logic [15:0]         mem [DEPTH];
  pwr_state_t          state, state_nxt;
  logic [3:0]          cmd;
  logic [3:0]          bank_open;
  logic [ROW_BITS-1:0] bank_row [4];
  logic [1:0]          trcd [4];
  logic [1:0]          mode_bl_log2;
  logic                mode_ilv, mode_cl3, mode_single;

  // active burst
  logic                bst_act, bst_rd, bst_ilv, bst_ap, bst_cl3;
  logic [1:0]          bst_ba, bst_bl_log2;
  logic [ROW_BITS-1:0] bst_row;
  logic [8:0]          bst_col;
  logic [2:0]          bst_k, bst_last_k;

  // read return pipeline
  logic                vld_p0, cl3_p0, vld_p1;
  logic [AW-1:0]       rd_addr_p0;
  logic [15:0]         rd_data_p1;
  logic [1:0]          dqm_q;

  logic run_ok, is_rw, rw_accept, bst_step, mode_ok;
  logic w_vld, w_rd, w_cl3;
  logic [AW-1:0] w_addr;
  logic unused_addr_hi;

  assign cmd            = {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
  assign unused_addr_hi = ^SDRAM_A[12:11];
  assign run_ok         = (INIT_CHECK == 0) || (state == RUN);
  assign is_rw          = (cmd == CMD_READ) || (cmd == CMD_WRITE);
  assign rw_accept      = is_rw && run_ok && bank_open[SDRAM_BA];
  assign bst_step       = bst_act && (cmd != CMD_BST) && !rw_accept;
  assign bst_last_k     = 3'((4'd1 << bst_bl_log2) - 4'd1);
  assign mode_ok        = !SDRAM_A[2] && ((SDRAM_A[6:4] == 3'd2) || (SDRAM_A[6:4] == 3'd3));

  // Word issued this edge: a newly accepted access wins over a running burst.
  always_comb begin
    w_vld  = 1'b0;
    w_rd   = 1'b0;
    w_cl3  = 1'b0;
    w_addr = '0;
    if (rw_accept) begin
      w_vld  = 1'b1;
      w_rd   = (cmd == CMD_READ);
      w_cl3  = mode_cl3;
      w_addr = {SDRAM_BA, bank_row[SDRAM_BA], SDRAM_A[8:0]};
    end else if (bst_step) begin
      w_vld  = 1'b1;
      w_rd   = bst_rd;
      w_cl3  = bst_cl3;
      w_addr = {bst_ba, bst_row, burst_col(bst_col, bst_k, bst_bl_log2, bst_ilv)};
    end
  end

  // Power-up state register.
  always_ff @(posedge clk) begin
    if (init) state <= WAIT_PRE;
    else      state <= state_nxt;
  end

  // Power-up next state: advances only on the expected command in order.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_PRE:  if (cmd == CMD_PRE && SDRAM_A[10]) state_nxt = WAIT_REF1;
      WAIT_REF1: if (cmd == CMD_REF)                state_nxt = WAIT_REF2;
      WAIT_REF2: if (cmd == CMD_REF)                state_nxt = WAIT_MODE;
      WAIT_MODE: if (cmd == CMD_LMR && mode_ok)     state_nxt = RUN;
      RUN:       state_nxt = RUN;
      default:   state_nxt = WAIT_PRE;
    endcase
  end

  // Power-up outputs.
  always_comb begin
    ready = (state == RUN);
  end

  // Bank, mode, burst and error bookkeeping.
  always_ff @(posedge clk) begin
    if (init) begin
      bank_open    <= '0;
      for (int i = 0; i < 4; i++) trcd[i] <= '0;
      mode_bl_log2 <= 2'd0;
      mode_ilv     <= 1'b0;
      mode_cl3     <= 1'b0;
      mode_single  <= 1'b0;
      bst_act      <= 1'b0;
      err          <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (trcd[i] != 2'd0) trcd[i] <= trcd[i] - 2'd1;

      // a burst ending or being cut short still honours its auto-precharge
      if (bst_step) begin
        bst_k <= bst_k + 3'd1;
        if (bst_k == bst_last_k) begin
          bst_act <= 1'b0;
          if (bst_ap) bank_open[bst_ba] <= 1'b0;
        end
      end else if (bst_act) begin
        bst_act <= 1'b0;
        if (bst_ap) bank_open[bst_ba] <= 1'b0;
      end

      case (cmd)
        CMD_ACTIVE: begin
          if (!run_ok) err[4] <= 1'b1;
          else begin
            if (bank_open[SDRAM_BA]) err[1] <= 1'b1;
            bank_open[SDRAM_BA] <= 1'b1;
            bank_row[SDRAM_BA]  <= SDRAM_A[ROW_BITS-1:0];
            trcd[SDRAM_BA]      <= 2'd2;
          end
        end
        CMD_READ, CMD_WRITE: begin
          if (!run_ok) err[4] <= 1'b1;
          else if (!bank_open[SDRAM_BA]) err[0] <= 1'b1;
          else begin
            if (trcd[SDRAM_BA] != 2'd0) err[2] <= 1'b1;
            bst_rd      <= (cmd == CMD_READ);
            bst_ba      <= SDRAM_BA;
            bst_row     <= bank_row[SDRAM_BA];
            bst_col     <= SDRAM_A[8:0];
            bst_k       <= 3'd1;
            bst_bl_log2 <= mode_bl_log2;
            bst_ilv     <= mode_ilv;
            bst_cl3     <= mode_cl3;
            bst_ap      <= SDRAM_A[10];
            if ((cmd == CMD_WRITE && mode_single) || mode_bl_log2 == 2'd0) begin
              bst_act <= 1'b0;
              if (SDRAM_A[10]) bank_open[SDRAM_BA] <= 1'b0;
            end else begin
              bst_act <= 1'b1;
            end
          end
        end
        CMD_PRE: begin
          if (SDRAM_A[10]) bank_open <= '0;
          else             bank_open[SDRAM_BA] <= 1'b0;
        end
        CMD_REF: begin
          if (|bank_open) err[3] <= 1'b1;
        end
        CMD_LMR: begin
          if (mode_ok) begin
            mode_bl_log2 <= SDRAM_A[1:0];
            mode_ilv     <= SDRAM_A[3];
            mode_cl3     <= (SDRAM_A[6:4] == 3'd3);
            mode_single  <= SDRAM_A[9];
          end else begin
            err[4] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write port: one word per edge, per-byte masked by DQM at the same edge.
  always_ff @(posedge clk) begin
    if (!init && w_vld && !w_rd) begin
      if (!SDRAM_DQML) mem[w_addr][7:0]  <= dq_in[7:0];
      if (!SDRAM_DQMH) mem[w_addr][15:8] <= dq_in[15:8];
    end
  end

  // Read pipeline data registers (address, CL3 holding stage, DQM history).
  always_ff @(posedge clk) begin
    rd_addr_p0 <= w_addr;
    cl3_p0     <= w_cl3;
    rd_data_p1 <= mem[rd_addr_p0];
    dqm_q      <= {SDRAM_DQMH, SDRAM_DQML};
  end

  // Read pipeline control and output: p0 -> bus for CL2, p0 -> p1 -> bus for CL3.
  always_ff @(posedge clk) begin
    if (init) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      dq_oe  <= 1'b0;
      dq_out <= '0;
    end else begin
      vld_p0 <= w_vld && w_rd;
      vld_p1 <= vld_p0 && cl3_p0;
      dq_oe  <= (vld_p0 && !cl3_p0) || vld_p1;
      if (vld_p0 && !cl3_p0) dq_out <= mask_read(mem[rd_addr_p0], dqm_q);
      else if (vld_p1)       dq_out <= mask_read(rd_data_p1, dqm_q);
      else                   dq_out <= '0;
    end
  end

endmodule

// File: tb/tb_sdram_model.sv
// Directed bench for sdram_model: a table of per-clock commands with
// hand-computed outputs, then an init-during-burst and re-power-up sequence.
module tb_sdram_model;

  localparam logic [3:0] LMR = 4'b0000, REF = 4'b0001, PRE = 4'b0010, ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100, RD  = 4'b0101, BST = 4'b0110, NOP = 4'b0111;

  logic        clk = 1'b0;
  logic        init;
  logic [3:0]  cmd_r;
  logic [1:0]  ba_r;
  logic [12:0] a_r;
  logic [1:0]  dqm_r;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        ready;
  logic [4:0]  err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [1:0]  dqm;
    logic [15:0] dq;
    logic        exp_oe;
    logic        chk_dq;
    logic [15:0] exp_dq;
    logic        exp_rdy;
    logic [4:0]  exp_err;
  } vec_t;

  vec_t vecs[$];

  sdram_model #(.ROW_BITS(4), .INIT_CHECK(1)) dut (
    .clk        (clk),
    .init       (init),
    .SDRAM_nCS  (cmd_r[3]),
    .SDRAM_nRAS (cmd_r[2]),
    .SDRAM_nCAS (cmd_r[1]),
    .SDRAM_nWE  (cmd_r[0]),
    .SDRAM_BA   (ba_r),
    .SDRAM_A    (a_r),
    .SDRAM_DQMH (dqm_r[1]),
    .SDRAM_DQML (dqm_r[0]),
    .dq_in      (dq_in),
    .dq_out     (dq_out),
    .dq_oe      (dq_oe),
    .ready      (ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one command across one rising edge, then settle past it.
  task automatic step(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                      input logic [1:0] dqm, input logic [15:0] d);
    cmd_r = c; ba_r = ba; a_r = a; dqm_r = dqm; dq_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [1:0] dqm, input logic [15:0] d, input logic oe,
                     input logic cd, input logic [15:0] ed, input logic rdy, input logic [4:0] e);
    vec_t v;
    v.cmd = c; v.ba = ba; v.a = a; v.dqm = dqm; v.dq = d;
    v.exp_oe = oe; v.chk_dq = cd; v.exp_dq = ed; v.exp_rdy = rdy; v.exp_err = e;
    vecs.push_back(v);
  endtask

  // Shorthands in RUN: a plain command with the bus idle, a NOP with the bus
  // idle, a NOP with a checked read word, a NOP with an unchecked read word.
  task automatic cq(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                    input logic [1:0] dqm, input logic [15:0] d, input logic [4:0] e);
    add(c, ba, a, dqm, d, 1'b0, 1'b0, 16'h0, 1'b1, e);
  endtask
  task automatic nq(input logic [4:0] e);
    add(NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, e);
  endtask
  task automatic wd(input logic [15:0] ed, input logic [4:0] e);
    add(NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b1, 1'b1, ed, 1'b1, e);
  endtask
  task automatic wx(input logic [4:0] e);
    add(NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1, e);
  endtask

  initial begin
    // power-up to BL4 CL2 sequential single-write
    add(PRE, 2'd0, 13'h400, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 5'h00);
    add(REF, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 5'h00);
    add(REF, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 5'h00);
    cq(LMR, 2'd0, 13'h222, 2'b00, 16'h0, 5'h00);
    // bank 1 row 3: clear cols 4,6,7, write col 5 with auto-precharge
    cq(ACT, 2'd1, 13'h003, 2'b00, 16'h0, 5'h00);
    nq(5'h00); nq(5'h00);
    cq(WR, 2'd1, 13'h004, 2'b00, 16'h0000, 5'h00);
    cq(WR, 2'd1, 13'h006, 2'b00, 16'h0000, 5'h00);
    cq(WR, 2'd1, 13'h007, 2'b00, 16'h0000, 5'h00);
    cq(WR, 2'd1, 13'h405, 2'b00, 16'hA55A, 5'h00);
    cq(ACT, 2'd1, 13'h003, 2'b00, 16'h0, 5'h00);
    nq(5'h00); nq(5'h00);
    cq(RD, 2'd1, 13'h404, 2'b00, 16'h0, 5'h00);
    wd(16'h0000, 5'h00); wd(16'hA55A, 5'h00); wd(16'h0000, 5'h00); wd(16'h0000, 5'h00);
    nq(5'h00);
    // byte-masked write over FFFF
    cq(ACT, 2'd1, 13'h003, 2'b00, 16'h0, 5'h00);
    nq(5'h00); nq(5'h00);
    cq(WR, 2'd1, 13'h008, 2'b00, 16'hFFFF, 5'h00);
    cq(WR, 2'd1, 13'h008, 2'b10, 16'h1234, 5'h00);
    cq(RD, 2'd1, 13'h008, 2'b00, 16'h0, 5'h00);
    wd(16'hFF34, 5'h00); wx(5'h00); wx(5'h00); wx(5'h00);
    nq(5'h00);
    // sequential ordering from col 6
    cq(WR, 2'd1, 13'h004, 2'b00, 16'h4444, 5'h00);
    cq(WR, 2'd1, 13'h005, 2'b00, 16'h5555, 5'h00);
    cq(WR, 2'd1, 13'h006, 2'b00, 16'h6666, 5'h00);
    cq(WR, 2'd1, 13'h007, 2'b00, 16'h7777, 5'h00);
    cq(RD, 2'd1, 13'h006, 2'b00, 16'h0, 5'h00);
    wd(16'h6666, 5'h00); wd(16'h7777, 5'h00); wd(16'h4444, 5'h00); wd(16'h5555, 5'h00);
    nq(5'h00);
    // interleaved ordering from col 6 and col 5
    cq(LMR, 2'd0, 13'h22A, 2'b00, 16'h0, 5'h00);
    cq(RD, 2'd1, 13'h006, 2'b00, 16'h0, 5'h00);
    wd(16'h6666, 5'h00); wd(16'h7777, 5'h00); wd(16'h4444, 5'h00); wd(16'h5555, 5'h00);
    cq(RD, 2'd1, 13'h005, 2'b00, 16'h0, 5'h00);
    wd(16'h5555, 5'h00); wd(16'h4444, 5'h00); wd(16'h7777, 5'h00); wd(16'h6666, 5'h00);
    nq(5'h00);
    // read to a closed bank is dropped
    cq(RD, 2'd2, 13'h000, 2'b00, 16'h0, 5'h01);
    nq(5'h01);
    // read one edge after ACTIVE still returns data
    cq(PRE, 2'd1, 13'h000, 2'b00, 16'h0, 5'h01);
    cq(ACT, 2'd1, 13'h003, 2'b00, 16'h0, 5'h01);
    cq(RD, 2'd1, 13'h004, 2'b00, 16'h0, 5'h05);
    wd(16'h4444, 5'h05); wd(16'h5555, 5'h05); wd(16'h6666, 5'h05); wd(16'h7777, 5'h05);
    nq(5'h05);
    // burst terminate after the first word
    cq(RD, 2'd1, 13'h004, 2'b00, 16'h0, 5'h05);
    add(BST, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 1'b1, 16'h4444, 1'b1, 5'h05);
    nq(5'h05);
    // a new read cuts the running burst short
    cq(RD, 2'd1, 13'h004, 2'b00, 16'h0, 5'h05);
    add(RD, 2'd1, 13'h006, 2'b00, 16'h0, 1'b1, 1'b1, 16'h4444, 1'b1, 5'h05);
    wd(16'h6666, 5'h05); wd(16'h7777, 5'h05); wd(16'h4444, 5'h05); wd(16'h5555, 5'h05);
    nq(5'h05);
    // CAS latency 3, interleaved
    cq(LMR, 2'd0, 13'h23A, 2'b00, 16'h0, 5'h05);
    cq(RD, 2'd1, 13'h004, 2'b00, 16'h0, 5'h05);
    nq(5'h05);
    wd(16'h4444, 5'h05); wd(16'h5555, 5'h05); wd(16'h6666, 5'h05); wd(16'h7777, 5'h05);
    nq(5'h05);
    // refresh with open bank, ACTIVE to open bank, bad mode kept out
    cq(REF, 2'd0, 13'h000, 2'b00, 16'h0, 5'h0D);
    cq(ACT, 2'd1, 13'h003, 2'b00, 16'h0, 5'h0F);
    cq(LMR, 2'd0, 13'h224, 2'b00, 16'h0, 5'h1F);
    cq(RD, 2'd1, 13'h004, 2'b00, 16'h0, 5'h1F);
    nq(5'h1F);
    wd(16'h4444, 5'h1F); wd(16'h5555, 5'h1F); wd(16'h6666, 5'h1F); wd(16'h7777, 5'h1F);
    nq(5'h1F);

    // reset state
    init = 1'b1;
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    chk("reset dq_oe", 32'(dq_oe), 32'd0);
    chk("reset dq_out", 32'(dq_out), 32'd0);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    init = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].cmd, vecs[i].ba, vecs[i].a, vecs[i].dqm, vecs[i].dq);
      chk($sformatf("v%0d dq_oe", i), 32'(dq_oe), 32'(vecs[i].exp_oe));
      chk($sformatf("v%0d ready", i), 32'(ready), 32'(vecs[i].exp_rdy));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      if (vecs[i].chk_dq) chk($sformatf("v%0d dq_out", i), 32'(dq_out), 32'(vecs[i].exp_dq));
    end

    // init pulse in the middle of a CL3 read burst
    step(RD, 2'd1, 13'h004, 2'b00, 16'h0);
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    chk("pre-init word0 oe", 32'(dq_oe), 32'd1);
    chk("pre-init word0", 32'(dq_out), 32'h4444);
    init = 1'b1;
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    chk("init dq_oe", 32'(dq_oe), 32'd0);
    chk("init dq_out", 32'(dq_out), 32'd0);
    chk("init ready", 32'(ready), 32'd0);
    chk("init err", 32'(err), 32'd0);
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    init = 1'b0;

    // access before power-up completes is rejected
    step(RD, 2'd1, 13'h004, 2'b00, 16'h0);
    chk("early read err", 32'(err), 32'h10);
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    chk("early read oe", 32'(dq_oe), 32'd0);
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    chk("early read oe2", 32'(dq_oe), 32'd0);

    // re-power-up; memory survived init
    step(PRE, 2'd0, 13'h400, 2'b00, 16'h0);
    step(REF, 2'd0, 13'h000, 2'b00, 16'h0);
    step(REF, 2'd0, 13'h000, 2'b00, 16'h0);
    chk("repower ready before mode", 32'(ready), 32'd0);
    step(LMR, 2'd0, 13'h222, 2'b00, 16'h0);
    chk("repower ready", 32'(ready), 32'd1);
    step(ACT, 2'd1, 13'h003, 2'b00, 16'h0);
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    step(RD, 2'd1, 13'h004, 2'b00, 16'h0);
    chk("kept read n oe", 32'(dq_oe), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
      chk($sformatf("kept word%0d oe", k), 32'(dq_oe), 32'd1);
      chk($sformatf("kept word%0d", k), 32'(dq_out), 32'h4444 + 32'(k) * 32'h1111);
    end
    step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    chk("kept tail oe", 32'(dq_oe), 32'd0);
    chk("kept err", 32'(err), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
